// File: rtl/idu_stage_if.sv
// Fetch-side and decode-side handshake bundle of the decode stage.
// The stage uses the slave modport; the IFU/EXU side drives the master modport.
interface idu_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        flush;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic        out_imm_for_alu;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic        out_reg_wen;
    logic [1:0]  out_wdata_sel;
    logic        out_mem_ren;
    logic        out_mem_wen;
    logic [1:0]  out_mem_size;
    logic        out_mem_unsigned;
    logic [1:0]  out_npc_sel;
    logic [4:0]  out_alu_op;
    logic        out_halt;
    logic        out_illegal;

    modport master (
        output in_valid, in_inst, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_imm, out_imm_for_alu,
               out_rs1, out_rs2, out_rd, out_reg_wen, out_wdata_sel,
               out_mem_ren, out_mem_wen, out_mem_size, out_mem_unsigned,
               out_npc_sel, out_alu_op, out_halt, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_imm, out_imm_for_alu,
               out_rs1, out_rs2, out_rd, out_reg_wen, out_wdata_sel,
               out_mem_ren, out_mem_wen, out_mem_size, out_mem_unsigned,
               out_npc_sel, out_alu_op, out_halt, out_illegal
    );
endinterface

// File: rtl/idu_stage.sv
// RV32I/E(+M) decode stage: combinational decode of the incoming word into a
// registered bundle, with an optional skid entry and sticky halt on EBREAK.
//
// state    | meaning
// ---------+---------------------------------------------------
// ST_EMPTY | no bundle held, out_valid = 0
// ST_ONE   | output entry valid
// ST_TWO   | output entry and skid entry valid (SKID=1 only)
module idu_stage #(
    parameter bit RVE      = 1'b0,
    parameter bit ENABLE_M = 1'b1,
    parameter bit SKID     = 1'b1
) (
    input logic         clk,
    input logic         rst,
    idu_stage_if.slave  bus
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic        imm_for_alu;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_wen;
        logic [1:0]  wdata_sel;
        logic        mem_ren;
        logic        mem_wen;
        logic [1:0]  mem_size;
        logic        mem_unsigned;
        logic [1:0]  npc_sel;
        logic [4:0]  alu_op;
        logic        halt;
        logic        illegal;
    } bundle_t;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    logic [31:0] inst;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1_f;
    logic [4:0]  rs2_f;
    logic [4:0]  rd_f;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign inst  = bus.in_inst;
    assign opc   = inst[6:0];
    assign rd_f  = inst[11:7];
    assign f3    = inst[14:12];
    assign rs1_f = inst[19:15];
    assign rs2_f = inst[24:20];
    assign f7    = inst[31:25];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    bundle_t dec;
    logic    legal;
    logic    use_rs1;
    logic    use_rs2;
    logic    use_rd;

    always_comb begin
        dec     = '0;
        legal   = 1'b1;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        dec.pc  = bus.in_pc;
        dec.rs1 = rs1_f;
        dec.rs2 = rs2_f;
        dec.rd  = rd_f;
        case (opc)
            OPC_LUI: begin
                dec.imm     = imm_u;
                dec.rs1     = 5'd0;
                dec.reg_wen = 1'b1;
                use_rd      = 1'b1;
            end
            OPC_AUIPC: begin
                dec.imm       = imm_u;
                dec.wdata_sel = 2'b10;
                dec.reg_wen   = 1'b1;
                use_rd        = 1'b1;
            end
            OPC_JAL: begin
                dec.imm       = imm_j;
                dec.wdata_sel = 2'b01;
                dec.npc_sel   = 2'b01;
                dec.reg_wen   = 1'b1;
                use_rd        = 1'b1;
            end
            OPC_JALR: begin
                dec.imm         = imm_i;
                dec.imm_for_alu = 1'b1;
                dec.wdata_sel   = 2'b01;
                dec.npc_sel     = 2'b10;
                dec.reg_wen     = 1'b1;
                use_rs1         = 1'b1;
                use_rd          = 1'b1;
                legal           = (f3 == 3'b000);
            end
            OPC_BRANCH: begin
                dec.imm     = imm_b;
                dec.npc_sel = 2'b01;
                dec.alu_op  = {2'b01, f3};
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
                legal       = (f3[2:1] != 2'b01);
            end
            OPC_LOAD: begin
                dec.imm          = imm_i;
                dec.imm_for_alu  = 1'b1;
                dec.wdata_sel    = 2'b11;
                dec.mem_ren      = 1'b1;
                dec.mem_size     = f3[1:0];
                dec.mem_unsigned = f3[2];
                dec.reg_wen      = 1'b1;
                use_rs1          = 1'b1;
                use_rd           = 1'b1;
                legal            = (f3 != 3'b011) && (f3[2:1] != 2'b11);
            end
            OPC_STORE: begin
                dec.imm         = imm_s;
                dec.imm_for_alu = 1'b1;
                dec.mem_wen     = 1'b1;
                dec.mem_size    = f3[1:0];
                use_rs1         = 1'b1;
                use_rs2         = 1'b1;
                legal           = !f3[2] && (f3[1:0] != 2'b11);
            end
            OPC_IMM: begin
                dec.imm         = imm_i;
                dec.imm_for_alu = 1'b1;
                dec.reg_wen     = 1'b1;
                // only SRAI borrows imm[10] as the alternate-op bit
                dec.alu_op      = {1'b0, f7[5] & (f3 == 3'b101), f3};
                use_rs1         = 1'b1;
                use_rd          = 1'b1;
                if (f3 == 3'b001)
                    legal = (f7 == 7'b0000000);
                else if (f3 == 3'b101)
                    legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
            end
            OPC_OP: begin
                dec.reg_wen = 1'b1;
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
                use_rd      = 1'b1;
                if (f7 == 7'b0000001) begin
                    dec.alu_op = {2'b10, f3};
                    legal      = ENABLE_M;
                end else if (f7 == 7'b0000000) begin
                    dec.alu_op = {2'b00, f3};
                end else if (f7 == 7'b0100000) begin
                    dec.alu_op = {2'b01, f3};
                    legal      = (f3 == 3'b000) || (f3 == 3'b101);
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_FENCE: begin
                legal = 1'b1;
            end
            OPC_SYSTEM: begin
                dec.halt = (inst == INST_EBREAK);
                legal    = (inst == INST_EBREAK) || (inst == INST_ECALL);
            end
            default: legal = 1'b0;
        endcase

        if (RVE && ((use_rs1 && rs1_f[4]) || (use_rs2 && rs2_f[4]) || (use_rd && rd_f[4])))
            legal = 1'b0;

        dec.illegal = !legal;
        if (!legal) begin
            dec.reg_wen = 1'b0;
            dec.mem_ren = 1'b0;
            dec.mem_wen = 1'b0;
            dec.npc_sel = 2'b00;
        end
    end

    state_t  state;
    bundle_t out_q;
    bundle_t skid_q;
    logic    halted;
    logic    accept;
    logic    out_fire;

    // Without a skid entry the stage may only accept when the output drains this cycle.
    assign bus.in_ready  = SKID ? ((state != ST_TWO) && !halted)
                                : (((state == ST_EMPTY) || bus.out_ready) && !halted);
    assign bus.out_valid = (state != ST_EMPTY);
    assign accept        = bus.in_valid && bus.in_ready;
    assign out_fire      = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_EMPTY;
            out_q  <= '0;
            skid_q <= '0;
            halted <= 1'b0;
        end else if (bus.flush) begin
            state  <= ST_EMPTY;
            halted <= 1'b0;
        end else begin
            if (accept && dec.halt)
                halted <= 1'b1;
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        out_q <= dec;
                        state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && out_fire) begin
                        out_q <= dec;
                    end else if (accept) begin
                        skid_q <= dec;
                        state  <= ST_TWO;
                    end else if (out_fire) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        out_q <= skid_q;
                        state <= ST_ONE;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    assign bus.out_pc           = out_q.pc;
    assign bus.out_imm          = out_q.imm;
    assign bus.out_imm_for_alu  = out_q.imm_for_alu;
    assign bus.out_rs1          = out_q.rs1;
    assign bus.out_rs2          = out_q.rs2;
    assign bus.out_rd           = out_q.rd;
    assign bus.out_reg_wen      = out_q.reg_wen;
    assign bus.out_wdata_sel    = out_q.wdata_sel;
    assign bus.out_mem_ren      = out_q.mem_ren;
    assign bus.out_mem_wen      = out_q.mem_wen;
    assign bus.out_mem_size     = out_q.mem_size;
    assign bus.out_mem_unsigned = out_q.mem_unsigned;
    assign bus.out_npc_sel      = out_q.npc_sel;
    assign bus.out_alu_op       = out_q.alu_op;
    assign bus.out_halt         = out_q.halt;
    assign bus.out_illegal      = out_q.illegal;

endmodule

// File: tb/tb_idu_stage.sv
// Directed bench for idu_stage: four parameter variants share one stimulus stream
// and are checked against hand-computed decode results.
module tb_idu_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] got[$];

    always #5 clk = ~clk;

    idu_stage_if if_a();
    idu_stage_if if_b();
    idu_stage_if if_c();
    idu_stage_if if_d();

    assign if_a.in_valid = in_valid;  assign if_a.in_inst = in_inst;  assign if_a.in_pc = in_pc;
    assign if_a.flush = flush;        assign if_a.out_ready = out_ready;
    assign if_b.in_valid = in_valid;  assign if_b.in_inst = in_inst;  assign if_b.in_pc = in_pc;
    assign if_b.flush = flush;        assign if_b.out_ready = out_ready;
    assign if_c.in_valid = in_valid;  assign if_c.in_inst = in_inst;  assign if_c.in_pc = in_pc;
    assign if_c.flush = flush;        assign if_c.out_ready = out_ready;
    assign if_d.in_valid = in_valid;  assign if_d.in_inst = in_inst;  assign if_d.in_pc = in_pc;
    assign if_d.flush = flush;        assign if_d.out_ready = out_ready;

    idu_stage #(.RVE(1'b0), .ENABLE_M(1'b1), .SKID(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    idu_stage #(.RVE(1'b0), .ENABLE_M(1'b0), .SKID(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    idu_stage #(.RVE(1'b1), .ENABLE_M(1'b1), .SKID(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));
    idu_stage #(.RVE(1'b0), .ENABLE_M(1'b1), .SKID(1'b0)) dut_d (.clk(clk), .rst(rst), .bus(if_d.slave));

    // record every bundle the EXU side takes from the default variant
    always @(negedge clk)
        if (!rst && !flush && if_a.out_valid && if_a.out_ready)
            got.push_back(if_a.out_pc);

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
        in_inst  = inst;
        in_pc    = pc;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
    endtask

    initial begin
        // reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", if_a.out_valid, 0);
        chk("rst_in_ready", if_a.in_ready, 1);
        chk("rst_out_pc", if_a.out_pc, 0);
        chk("rst_out_imm", if_a.out_imm, 0);
        chk("rst_d_in_ready", if_d.in_ready, 1);

        // ADDI x5,x0,-1
        out_ready = 1'b1;
        issue(32'hFFF0_0293, 32'h8000_0000);
        chk("addi_valid", if_a.out_valid, 1);
        chk("addi_pc", if_a.out_pc, 32'h8000_0000);
        chk("addi_imm", if_a.out_imm, 32'hFFFF_FFFF);
        chk("addi_rd", if_a.out_rd, 5);
        chk("addi_rs1", if_a.out_rs1, 0);
        chk("addi_reg_wen", if_a.out_reg_wen, 1);
        chk("addi_alu_op", if_a.out_alu_op, 0);
        chk("addi_imm_for_alu", if_a.out_imm_for_alu, 1);
        chk("addi_illegal", if_a.out_illegal, 0);
        chk("addi_d_valid", if_d.out_valid, 1);
        step();
        chk("addi_drained", if_a.out_valid, 0);

        // MUL x1,x2,x3 across M/RVE variants
        issue(32'h0231_00B3, 32'h0000_0100);
        chk("mul_a_illegal", if_a.out_illegal, 0);
        chk("mul_a_alu_op", if_a.out_alu_op, 5'b10000);
        chk("mul_a_rs1", if_a.out_rs1, 2);
        chk("mul_a_rs2", if_a.out_rs2, 3);
        chk("mul_a_rd", if_a.out_rd, 1);
        chk("mul_b_illegal", if_b.out_illegal, 1);
        chk("mul_b_reg_wen", if_b.out_reg_wen, 0);
        chk("mul_c_illegal", if_c.out_illegal, 0);
        chk("mul_c_reg_wen", if_c.out_reg_wen, 1);

        // ADD x17,x1,x1
        issue(32'h0010_88B3, 32'h0000_0104);
        chk("add17_a_illegal", if_a.out_illegal, 0);
        chk("add17_a_rd", if_a.out_rd, 17);
        chk("add17_c_illegal", if_c.out_illegal, 1);
        chk("add17_c_reg_wen", if_c.out_reg_wen, 0);

        // SUB x3,x1,x2
        issue(32'h4020_81B3, 32'h0000_0108);
        chk("sub_alu_op", if_a.out_alu_op, 5'b01000);
        chk("sub_imm", if_a.out_imm, 0);

        // LBU x5,4(x1)
        issue(32'h0040_C283, 32'h0000_010C);
        chk("lbu_mem_ren", if_a.out_mem_ren, 1);
        chk("lbu_mem_unsigned", if_a.out_mem_unsigned, 1);
        chk("lbu_mem_size", if_a.out_mem_size, 0);
        chk("lbu_wdata_sel", if_a.out_wdata_sel, 2'b11);
        chk("lbu_imm", if_a.out_imm, 4);
        chk("lbu_rs1", if_a.out_rs1, 1);

        // unrecognised opcode
        issue(32'hFFFF_FFFF, 32'h0000_0110);
        chk("badop_illegal", if_a.out_illegal, 1);
        chk("badop_reg_wen", if_a.out_reg_wen, 0);
        chk("badop_npc_sel", if_a.out_npc_sel, 0);
        chk("badop_pc", if_a.out_pc, 32'h0000_0110);

        // BNE x1,x2,-4
        issue(32'hFE20_9EE3, 32'h0000_0114);
        chk("bne_imm", if_a.out_imm, 32'hFFFF_FFFC);
        chk("bne_npc_sel", if_a.out_npc_sel, 2'b01);
        chk("bne_alu_op", if_a.out_alu_op, 5'b01001);
        chk("bne_reg_wen", if_a.out_reg_wen, 0);
        step();

        // backpressure: three back-to-back, only two fit
        got.delete();
        out_ready = 1'b0;
        in_inst   = 32'h0010_0093;
        in_valid  = 1'b1;
        in_pc     = 32'h0;
        #1;
        chk("bp_ready0", if_a.in_ready, 1);
        step();
        in_pc = 32'h4;
        #1;
        chk("bp_ready1", if_a.in_ready, 1);
        chk("bp_d_ready1", if_d.in_ready, 0);
        step();
        in_pc = 32'h8;
        #1;
        chk("bp_ready2", if_a.in_ready, 0);
        chk("bp_pc_hold0", if_a.out_pc, 32'h0);
        step();
        out_ready = 1'b1;
        #1;
        chk("bp_valid_hold", if_a.out_valid, 1);
        chk("bp_pc_hold1", if_a.out_pc, 32'h0);
        step();
        #1;
        chk("bp_pc_skid", if_a.out_pc, 32'h4);
        chk("bp_ready_again", if_a.in_ready, 1);
        chk("bp_d_pc", if_d.out_pc, 32'h8);
        step();
        in_valid = 1'b0;
        #1;
        chk("bp_pc_third", if_a.out_pc, 32'h8);
        chk("bp_valid_third", if_a.out_valid, 1);
        step();
        #1;
        chk("bp_drained", if_a.out_valid, 0);
        chk("bp_count", got.size(), 3);
        if (got.size() == 3) begin
            chk("bp_order0", got[0], 32'h0);
            chk("bp_order1", got[1], 32'h4);
            chk("bp_order2", got[2], 32'h8);
        end

        // flush with both entries full and a same-cycle incoming instruction
        got.delete();
        out_ready = 1'b0;
        issue(32'h0010_0093, 32'h0000_0200);
        issue(32'h0010_0093, 32'h0000_0204);
        in_pc    = 32'h0000_0208;
        in_valid = 1'b1;
        flush    = 1'b1;
        #1;
        chk("fl_full_ready", if_a.in_ready, 0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("fl_valid", if_a.out_valid, 0);
        chk("fl_ready", if_a.in_ready, 1);
        chk("fl_d_valid", if_d.out_valid, 0);
        out_ready = 1'b1;
        step();
        step();
        chk("fl_still_empty", if_a.out_valid, 0);
        issue(32'h0010_0093, 32'h0000_0300);
        chk("fl_next_pc", if_a.out_pc, 32'h0000_0300);
        step();
        chk("fl_no_stale", if_a.out_valid, 0);
        chk("fl_count", got.size(), 1);

        // halt on EBREAK
        issue(32'h0010_0073, 32'h0000_0400);
        chk("hlt_valid", if_a.out_valid, 1);
        chk("hlt_halt", if_a.out_halt, 1);
        chk("hlt_illegal", if_a.out_illegal, 0);
        chk("hlt_reg_wen", if_a.out_reg_wen, 0);
        chk("hlt_ready", if_a.in_ready, 0);
        chk("hlt_d_ready", if_d.in_ready, 0);
        in_inst  = 32'h0010_0093;
        in_pc    = 32'h0000_0404;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hlt_ready_stuck", if_a.in_ready, 0);
        end
        chk("hlt_drained", if_a.out_valid, 0);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("hlt_flush_ready", if_a.in_ready, 1);
        chk("hlt_flush_drop", if_a.out_valid, 0);

        // reset in the middle of holding a bundle
        out_ready = 1'b0;
        issue(32'h0010_0093, 32'h0000_0500);
        chk("mr_held", if_a.out_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mr_valid", if_a.out_valid, 0);
        chk("mr_pc", if_a.out_pc, 0);
        chk("mr_ready", if_a.in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/idu_stage.md
Name: idu_stage

Overview:
- Registered, parametrised RV32I/E(+M) decode stage for the NPC pipeline, sitting between IFU and EXU.
- Accepts fetched instruction/PC over a valid/ready handshake and decodes it.
- Presents a registered decoded bundle downstream, with an optional skid entry for full throughput under backpressure.
- Adds illegal-instruction detection, RV32E register limiting, optional M extension, pipeline flush and sticky halt on EBREAK.

Parameters:
- RVE, 0: 1 limits the register file to x0–x15; any rs1/rs2/rd index ≥16 on a used field is illegal.
- ENABLE_M, 1: 0 makes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU illegal.
- SKID, 1: 1 adds a second (skid) entry so in_ready does not depend on out_ready; 0 gives a single output register.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  IFU has an instruction.
- in_ready  out  1  stage can accept.
- in_inst  in  32  instruction word.
- in_pc  in  32  instruction PC.
- flush  in  1  discard all held and incoming entries this cycle.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  EXU accepts.
- out_pc  out  32  PC of the decoded instruction.
- out_imm  out  32  sign-extended U/J/B/I/S immediate; 0 for R-type.
- out_imm_for_alu  out  1  I- or S-type.
- out_rs1, out_rs2, out_rd  out  5 each  register indices; rs1 forced to 0 for LUI.
- out_reg_wen  out  1  U/J/I/R-type and not illegal.
- out_wdata_sel  out  2  bit0 = JAL|JALR|load; bit1 = AUIPC|load.
- out_mem_ren, out_mem_wen  out  1 each  load / store.
- out_mem_size  out  2  funct3[1:0] for loads/stores, else 0.
- out_mem_unsigned  out  1  funct3[2] for loads.
- out_npc_sel  out  2  01 = JAL or branch, 10 = JALR, 00 = sequential.
- out_alu_op  out  5  see Behaviour.
- out_halt  out  1  bundle is EBREAK.
- out_illegal  out  1  bundle is an illegal instruction.

Behaviour:
- **Reset:** all out_* = 0, in_ready = 1, both entries empty, halted = 0.
- **Decode rules:** combinational on in_inst. Opcode/funct3/funct7 qualification identical to RV32IM.
- **Illegal:**
  - Unrecognised opcode.
  - Unused funct3 in load/store/branch/JALR.
  - Wrong funct7 in OP, or for SLLI/SRLI/SRAI.
  - M instruction with ENABLE_M=0.
  - RVE index violation.
- **Illegal bundles:** reg_wen, mem_ren, mem_wen = 0 and npc_sel = 00; pc is kept.
- **alu_op:**
  - OP/OP-IMM: {M-instr, funct7[5] for SUB/SRA/SRAI only, funct3}.
  - Branch: {2'b01, funct3}; EXU interprets it under npc_sel==01.
  - All others: 00000 (ADD).
- **Latency:** an instruction accepted in cycle N is on out_* in cycle N+1 if the output entry is free.
- **Handshake:** a transfer occurs when valid & ready. out_* are stable while out_valid & !out_ready.
- **States (SKID=1):** EMPTY, ONE (output valid), TWO (output + skid full).
  - EMPTY→ONE on accept.
  - ONE→TWO on accept & !out_ready.
  - ONE→EMPTY on out fire without accept.
  - TWO→ONE on out fire; the skid entry moves to output next cycle.
- **in_ready (SKID=1):** in_ready = !TWO & !halted.
- **SKID=0:** single entry. in_ready = (!out_valid | out_ready) & !halted, so simultaneous accept and drain is allowed.
- **Flush:** highest priority. Next cycle is EMPTY with out_valid = 0; any same-cycle in_valid is dropped; halted is cleared.
- **Halt:** accepting EBREAK sets halted. in_ready stays 0 until flush or rst. EBREAK still drains downstream with out_halt = 1.
- **Reset mid-operation:** rst overrides everything; contents are discarded.
- **Ordering:** strict FIFO order, no reordering.

Test Plan:
- **Simple decode:** rst, then ADDI x5,x0,-1 (0xFFF00293), pc 0x80000000, with out_ready = 1 → next cycle out_valid = 1, imm = 0xFFFFFFFF, rd = 5, reg_wen = 1, alu_op = 00000, imm_for_alu = 1.
- **Backpressure (SKID=1):** out_ready = 0, feed 3 back-to-back instructions → two accepted; in_ready = 0 on the 3rd. Raise out_ready → emitted in order with PCs 0x0, 0x4, 0x8, no loss or duplication.
- **Illegal and M gating:** MUL x1,x2,x3 (0x023100B3) with ENABLE_M = 0 → out_illegal = 1, reg_wen = 0. Same instruction with RVE = 1 and ENABLE_M = 1 → legal. ADD x17,x1,x1 with RVE = 1 → illegal.
- **Flush:** flush in the same cycle as in_valid, with both entries full → next cycle out_valid = 0, in_ready = 1, and no dropped instruction ever appears.
- **Halt:** EBREAK (0x00100073) → out_halt = 1, in_ready stays 0 for ≥10 cycles. Then flush → in_ready = 1.
- **Branch immediate:** BNE x1,x2,-4 (0xFE209EE3) → imm = 0xFFFFFFFC, npc_sel = 01, alu_op = 01001, reg_wen = 0.
